mod_counter: RTL and testbench
==============================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MAX, default 2**WIDTH-1, giving the terminal value; legal range 1..2**WIDTH-1.
REQ-003 The block SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port en  input  1  count enable.
REQ-006 The block SHALL have port up  input  1  direction: 1 counts up, 0 counts down.
REQ-007 The block SHALL have port clr  input  1  synchronous clear to zero.
REQ-008 The block SHALL have port load  input  1  synchronous load strobe.
REQ-009 The block SHALL have port load_val  input  WIDTH  value for load.
REQ-010 The block SHALL have port q  output  WIDTH  registered count value.
REQ-011 The block SHALL have port tc  output  1  terminal-count indicator, combinational.
REQ-012 The block SHALL have port wrap  output  1  registered one-cycle pulse following a wrap event.
REQ-013 The block SHALL have port ovf  output  1  sticky wrap flag (see Configuration).

Function
REQ-014 Next-state priority SHALL be clr > load > en > hold, evaluated each rising clock edge.
REQ-015 clr=1: q SHALL become 0; wrap SHALL be 0 next cycle; ovf SHALL clear to 0.
REQ-016 load=1 (clr=0): q SHALL become load_val if load_val<=MAX, else MAX (clamp); no wrap event.
REQ-017 en=1, up=1, q<MAX: q SHALL become q+1; at q==MAX: q SHALL become 0 (wrap event).
REQ-018 en=1, up=0, q>0: q SHALL become q-1; at q==0: q SHALL become MAX (wrap event).
REQ-019 en=0 with clr=0, load=0: q SHALL hold.
REQ-020 tc SHALL equal en & ~clr & ~load & ((up & q==MAX) | (~up & q==0)), i.e. high in exactly the cycle whose edge wraps.
REQ-021 wrap SHALL be 1 for exactly the one cycle after each wrap event, else 0; back-to-back wraps (MAX=1 or repeated) SHALL give consecutive wrap pulses.
REQ-022 Direction changes SHALL take effect on the same edge with no dead cycle.
REQ-023 q SHALL never hold a value above MAX after any edge, including after reset or load.
REQ-024 All arithmetic SHALL be WIDTH bits, with no carry out of the WIDTH-bit counter other than the defined wrap.

Reset
REQ-025 reset=1 SHALL immediately, independent of clock, force q=0, wrap=0, ovf=0.
REQ-026 Reset asserted mid-count SHALL abandon the count; the first edge after deassertion SHALL apply normal REQ-014 priority from q=0.
REQ-027 tc SHALL be evaluated from the reset value q=0 while reset is held; it is therefore 1 when en=1, up=0, clr=0 and load=0.

Configuration
REQ-028 Macro MOD_COUNTER_OVF_STICKY_EN defined: ovf SHALL set on the first edge carrying a wrap event and stay 1 until clr or reset.
REQ-029 Macro MOD_COUNTER_OVF_STICKY_EN undefined: ovf SHALL be tied constant 0 and no sticky register SHALL be synthesised; all other behaviour SHALL be unchanged.

Verification
REQ-030 WIDTH=5, MAX=31, en=1, up=1 from reset for 33 edges -> q runs 0..31,0,1; tc=1 only when q=31; wrap=1 only the cycle q=0 after wrap; ovf=1 afterwards iff macro defined.
REQ-031 WIDTH=5, MAX=9, up=0 from q=0 -> tc=1 at q=0, next q=9, wrap pulse once; continuing counts down 8,7,...
REQ-032 MAX=9, load=1, load_val=20 -> q=9 next edge; load=1 and en=1 with up=1 at q=9 -> q=load_val (load wins), tc=0, no wrap pulse.
REQ-033 clr, load and en all 1 at q=5 -> q=0, ovf cleared; clr=0, load=0, en=0 for 3 edges -> q holds 0.
REQ-034 reset pulsed between edges at q=17 (MAX=31) -> q=0, wrap=0, ovf=0 immediately; the first edge after release with en=1, up=1 gives q=1.
REQ-035 MAX=1, en=1, up=1 for 4 edges -> q 1,0,1,0; wrap high on the cycles where q=0 after a wrap; tc toggles with q.

Source files
------------

// File: rtl/mod_counter.sv
// Up/down modulo counter with clear, clamped load, terminal count and wrap pulse.
// Define MOD_COUNTER_OVF_STICKY_EN to build the sticky overflow flag on ovf.
module mod_counter #(
    parameter int              WIDTH = 5,
    parameter logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_wrap_evt;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_at_max       = (r_q == MAX);
    assign w_at_zero      = (r_q == '0);
    assign w_wrap_evt     = en & ~clr & ~load
                          & ((up & w_at_max) | (~up & w_at_zero));
    assign w_load_clamped = (load_val > MAX) ? MAX : load_val;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            // wrap event already excludes clr and load
            r_wrap <= w_wrap_evt;
            if (clr) begin
                r_q <= '0;
            end else if (load) begin
                r_q <= w_load_clamped;
            end else if (en) begin
                if (up) begin
                    r_q <= w_at_max ? '0 : r_q + WIDTH'(1);
                end else begin
                    r_q <= w_at_zero ? MAX : r_q - WIDTH'(1);
                end
            end
        end
    end

`ifdef MOD_COUNTER_OVF_STICKY_EN
    logic r_ovf;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_ovf <= 1'b0;
        end else if (w_wrap_evt) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign q    = r_q;
    assign tc   = w_wrap_evt;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: three instances (MAX 31, 9, 1) on shared inputs.
// Expected ovf follows MOD_COUNTER_OVF_STICKY_EN.
module tb_mod_counter;

`ifdef MOD_COUNTER_OVF_STICKY_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_val = '0;

    logic [4:0] q31, q9, q1;
    logic       tc31, tc9, tc1;
    logic       wrap31, wrap9, wrap1;
    logic       ovf31, ovf9, ovf1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mod_counter #(.WIDTH(5), .MAX(5'd31)) d31 (
        .clock(clock), .reset(reset), .en(en), .up(up), .clr(clr),
        .load(load), .load_val(load_val),
        .q(q31), .tc(tc31), .wrap(wrap31), .ovf(ovf31)
    );

    mod_counter #(.WIDTH(5), .MAX(5'd9)) d9 (
        .clock(clock), .reset(reset), .en(en), .up(up), .clr(clr),
        .load(load), .load_val(load_val),
        .q(q9), .tc(tc9), .wrap(wrap9), .ovf(ovf9)
    );

    mod_counter #(.WIDTH(5), .MAX(5'd1)) d1 (
        .clock(clock), .reset(reset), .en(en), .up(up), .clr(clr),
        .load(load), .load_val(load_val),
        .q(q1), .tc(tc1), .wrap(wrap1), .ovf(ovf1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    endtask

    task automatic reset_pulse();
        @(negedge clock);
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2;
        checks++;
        if (q31 !== 5'd0 || wrap31 !== 1'b0 || ovf31 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state q=%0d wrap=%b ovf=%b want 0 0 0",
                     q31, wrap31, ovf31);
        end
        en = 1'b1; up = 1'b0;
        #1;
        checks++;
        if (tc31 !== 1'b1) begin
            errors++;
            $display("FAIL reset_tc_down got %b want 1", tc31);
        end
        up = 1'b1;
        #1;
        checks++;
        if (tc31 !== 1'b0) begin
            errors++;
            $display("FAIL reset_tc_up got %b want 0", tc31);
        end
        idle_inputs();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_count_up();
        logic [4:0] eq;
        reset_pulse();
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            tick();
            eq = 5'(i % 32);
            checks++;
            if (q31 !== eq) begin
                errors++;
                $display("FAIL up31_q step %0d got %0d want %0d", i, q31, eq);
            end
            checks++;
            if (tc31 !== (eq == 5'd31)) begin
                errors++;
                $display("FAIL up31_tc step %0d got %b want %b",
                         i, tc31, eq == 5'd31);
            end
            checks++;
            if (wrap31 !== (i == 32)) begin
                errors++;
                $display("FAIL up31_wrap step %0d got %b want %b",
                         i, wrap31, i == 32);
            end
        end
        checks++;
        if (ovf31 !== OVF_EN) begin
            errors++;
            $display("FAIL up31_ovf got %b want %b", ovf31, OVF_EN);
        end
        idle_inputs();
    endtask

    task automatic test_count_down();
        reset_pulse();
        en = 1'b1; up = 1'b0;
        #1;
        checks++;
        if (tc9 !== 1'b1) begin
            errors++;
            $display("FAIL down9_tc0 got %b want 1", tc9);
        end
        tick();
        checks++;
        if (q9 !== 5'd9 || wrap9 !== 1'b1) begin
            errors++;
            $display("FAIL down9_wrap q=%0d wrap=%b want 9 1", q9, wrap9);
        end
        for (int i = 8; i >= 6; i--) begin
            tick();
            checks++;
            if (q9 !== 5'(i) || wrap9 !== 1'b0 || tc9 !== 1'b0) begin
                errors++;
                $display("FAIL down9_step q=%0d wrap=%b tc=%b want %0d 0 0",
                         q9, wrap9, tc9, i);
            end
        end
        idle_inputs();
    endtask

    task automatic test_load();
        load = 1'b1; load_val = 5'd20;
        tick();
        checks++;
        if (q9 !== 5'd9) begin
            errors++;
            $display("FAIL load_clamp got %0d want 9", q9);
        end
        load_val = 5'd3; en = 1'b1; up = 1'b1;
        #1;
        checks++;
        if (tc9 !== 1'b0) begin
            errors++;
            $display("FAIL load_tc got %b want 0", tc9);
        end
        tick();
        checks++;
        if (q9 !== 5'd3 || wrap9 !== 1'b0) begin
            errors++;
            $display("FAIL load_wins q=%0d wrap=%b want 3 0", q9, wrap9);
        end
        idle_inputs();
    endtask

    task automatic test_clr_priority();
        reset_pulse();
        en = 1'b1; up = 1'b0;
        tick();
        en = 1'b0; load = 1'b1; load_val = 5'd5;
        tick();
        checks++;
        if (q31 !== 5'd5 || ovf31 !== OVF_EN) begin
            errors++;
            $display("FAIL clr_setup q=%0d ovf=%b want 5 %b",
                     q31, ovf31, OVF_EN);
        end
        clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1;
        tick();
        checks++;
        if (q31 !== 5'd0 || ovf31 !== 1'b0 || wrap31 !== 1'b0) begin
            errors++;
            $display("FAIL clr_wins q=%0d ovf=%b wrap=%b want 0 0 0",
                     q31, ovf31, wrap31);
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q31 !== 5'd0) begin
                errors++;
                $display("FAIL hold_zero edge %0d got %0d want 0", i, q31);
            end
        end
    endtask

    task automatic test_reset_mid();
        load = 1'b1; load_val = 5'd17;
        tick();
        checks++;
        if (q31 !== 5'd17) begin
            errors++;
            $display("FAIL mid_load got %0d want 17", q31);
        end
        load = 1'b0; en = 1'b1; up = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (q31 !== 5'd0 || wrap31 !== 1'b0 || ovf31 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset q=%0d wrap=%b ovf=%b want 0 0 0",
                     q31, wrap31, ovf31);
        end
        #1;
        reset = 1'b0;
        tick();
        checks++;
        if (q31 !== 5'd1) begin
            errors++;
            $display("FAIL mid_release got %0d want 1", q31);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [4:0] eq;
        reset_pulse();
        en = 1'b1; up = 1'b1;
        #1;
        checks++;
        if (q1 !== 5'd0 || tc1 !== 1'b0) begin
            errors++;
            $display("FAIL max1_start q=%0d tc=%b want 0 0", q1, tc1);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            eq = 5'(i % 2);
            checks++;
            if (q1 !== eq || tc1 !== (eq == 5'd1) || wrap1 !== (eq == 5'd0)) begin
                errors++;
                $display("FAIL max1 step %0d q=%0d tc=%b wrap=%b want %0d %b %b",
                         i, q1, tc1, wrap1, eq, eq == 5'd1, eq == 5'd0);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_clr_priority();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
